// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, resolve-stage state enum and counter width
package cpu_pkg;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/bex_resolve_if.sv
// rtl/bex_resolve_if.sv - X-stage control-flow inputs and redirect/counter outputs
interface bex_resolve_if #(
  parameter int CNT_W = 16
);

  logic             valid_x;
  logic [4:0]       opcode_x;
  logic [31:0]      pc_plus1_x;
  logic [16:0]      imm_x;
  logic [26:0]      target_x;
  logic [31:0]      rd_val_x;
  logic             cmp_ne;
  logic             cmp_lt;
  logic             pass;
  logic [31:0]      rstatus_byp;
  logic [31:0]      rstatus_rf;
  logic             stall_in;

  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_fd;
  logic             flush_dx;
  logic             busy;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // Resolve stage side
  modport slave (
    input  valid_x, opcode_x, pc_plus1_x, imm_x, target_x, rd_val_x,
    input  cmp_ne, cmp_lt, pass, rstatus_byp, rstatus_rf, stall_in,
    output redirect, redirect_pc, flush_fd, flush_dx, busy,
    output resolved_cnt, taken_cnt
  );

  // Pipeline / driver side
  modport master (
    output valid_x, opcode_x, pc_plus1_x, imm_x, target_x, rd_val_x,
    output cmp_ne, cmp_lt, pass, rstatus_byp, rstatus_rf, stall_in,
    input  redirect, redirect_pc, flush_fd, flush_dx, busy,
    input  resolved_cnt, taken_cnt
  );

endinterface

// File: rtl/br_target_sel.sv
// rtl/br_target_sel.sv - combinational taken flag and target address selection
module br_target_sel
  import cpu_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic        cmp_ne,
  input  logic        cmp_lt,
  input  logic        pass,
  input  logic [31:0] rstatus_byp,
  input  logic [31:0] rstatus_rf,
  input  logic [31:0] pc_plus1,
  input  logic [16:0] imm,
  input  logic [26:0] target,
  input  logic [31:0] rd_val,
  output logic        is_cf,
  output logic        taken,
  output logic [31:0] target_pc
);

  logic [31:0] status;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;

  // bex tests the forwarded $r30 when the bypass check says the RF copy is stale
  assign status    = pass ? rstatus_byp : rstatus_rf;
  assign branch_pc = pc_plus1 + {{15{imm[16]}}, imm};
  assign jump_pc   = {5'b00000, target};

  // Decode the control-flow class and pick the matching target
  always_comb begin
    is_cf     = 1'b0;
    taken     = 1'b0;
    target_pc = jump_pc;
    case (opcode)
      OP_J, OP_JAL: begin
        is_cf = 1'b1;
        taken = 1'b1;
      end
      OP_JR: begin
        is_cf     = 1'b1;
        taken     = 1'b1;
        target_pc = rd_val;
      end
      OP_BNE: begin
        is_cf     = 1'b1;
        taken     = cmp_ne;
        target_pc = branch_pc;
      end
      OP_BLT: begin
        is_cf     = 1'b1;
        taken     = cmp_lt;
        target_pc = branch_pc;
      end
      OP_BEX: begin
        is_cf = 1'b1;
        taken = (status != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bex_resolve.sv
// rtl/bex_resolve.sv - execute-stage redirect FSM with saturating control-flow counters
module bex_resolve
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic        clock,
  input logic        reset_n,
  bex_resolve_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_next;
  logic [31:0]      pc_q, pc_next;
  logic [CNT_W-1:0] res_q, res_next;
  logic [CNT_W-1:0] tak_q, tak_next;

  logic             is_cf;
  logic             taken;
  logic [31:0]      target_pc;

  br_target_sel u_sel (
    .opcode      (bus.opcode_x),
    .cmp_ne      (bus.cmp_ne),
    .cmp_lt      (bus.cmp_lt),
    .pass        (bus.pass),
    .rstatus_byp (bus.rstatus_byp),
    .rstatus_rf  (bus.rstatus_rf),
    .pc_plus1    (bus.pc_plus1_x),
    .imm         (bus.imm_x),
    .target      (bus.target_x),
    .rd_val      (bus.rd_val_x),
    .is_cf       (is_cf),
    .taken       (taken),
    .target_pc   (target_pc)
  );

  // Next-state: resolve only real, unstalled instructions in IDLE; REDIRECT holds while stalled
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    res_next   = res_q;
    tak_next   = tak_q;
    case (state)
      ST_IDLE: begin
        if (bus.valid_x && is_cf && !bus.stall_in) begin
          res_next = (res_q == CNT_MAX) ? res_q : res_q + CNT_ONE;
          if (taken) begin
            tak_next   = (tak_q == CNT_MAX) ? tak_q : tak_q + CNT_ONE;
            pc_next    = target_pc;
            state_next = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        if (!bus.stall_in) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, registered target and counters; reset abandons any pending redirect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pc_q  <= 32'd0;
      res_q <= '0;
      tak_q <= '0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      res_q <= res_next;
      tak_q <= tak_next;
    end
  end

  // Redirect and squash come straight from the state flop, never from inputs
  assign bus.redirect     = (state == ST_REDIRECT);
  assign bus.flush_fd     = (state == ST_REDIRECT);
  assign bus.flush_dx     = (state == ST_REDIRECT);
  assign bus.busy         = (state == ST_REDIRECT);
  assign bus.redirect_pc  = pc_q;
  assign bus.resolved_cnt = res_q;
  assign bus.taken_cnt    = tak_q;

endmodule

// File: tb/tb_bex_resolve.sv
// tb/tb_bex_resolve.sv - directed scoreboard bench for bex_resolve
module tb_bex_resolve;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bex_resolve_if #(.CNT_W(16)) b0 ();
  bex_resolve_if #(.CNT_W(4))  b1 ();

  bex_resolve #(.CNT_W(16)) u0 (.clock(clock), .reset_n(reset_n), .bus(b0));
  bex_resolve #(.CNT_W(4))  u1 (.clock(clock), .reset_n(reset_n), .bus(b1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        red;
    logic [31:0] pc;
    logic [15:0] res;
    logic [15:0] tak;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic red, input logic [31:0] pc,
                      input logic [15:0] res, input logic [15:0] tak);
    exp_t e;
    e.tag = tag;
    e.red = red;
    e.pc  = pc;
    e.res = res;
    e.tak = tak;
    sb.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".redirect"}, 32'(b0.redirect), 32'(e.red));
      chk({e.tag, ".flush_fd"}, 32'(b0.flush_fd), 32'(e.red));
      chk({e.tag, ".flush_dx"}, 32'(b0.flush_dx), 32'(e.red));
      chk({e.tag, ".busy"},     32'(b0.busy),     32'(e.red));
      chk({e.tag, ".pc"},       b0.redirect_pc,   e.pc);
      chk({e.tag, ".resolved"}, 32'(b0.resolved_cnt), 32'(e.res));
      chk({e.tag, ".taken"},    32'(b0.taken_cnt),    32'(e.tak));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    compare_now();
  endtask

  task automatic instr0(input logic v, input logic [4:0] op, input logic ne, input logic lt,
                        input logic ps, input logic [31:0] byp, input logic [31:0] rf,
                        input logic [31:0] pc1, input logic [16:0] imm, input logic [26:0] tgt,
                        input logic [31:0] rdv);
    b0.valid_x     = v;
    b0.opcode_x    = op;
    b0.cmp_ne      = ne;
    b0.cmp_lt      = lt;
    b0.pass        = ps;
    b0.rstatus_byp = byp;
    b0.rstatus_rf  = rf;
    b0.pc_plus1_x  = pc1;
    b0.imm_x       = imm;
    b0.target_x    = tgt;
    b0.rd_val_x    = rdv;
  endtask

  task automatic idle0();
    instr0(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 17'd0, 27'd0, 32'd0);
    b0.stall_in = 1'b0;
  endtask

  task automatic idle1();
    b1.valid_x     = 1'b0;
    b1.opcode_x    = 5'd0;
    b1.cmp_ne      = 1'b0;
    b1.cmp_lt      = 1'b0;
    b1.pass        = 1'b0;
    b1.rstatus_byp = 32'd0;
    b1.rstatus_rf  = 32'd0;
    b1.pc_plus1_x  = 32'd0;
    b1.imm_x       = 17'd0;
    b1.target_x    = 27'd0;
    b1.rd_val_x    = 32'd0;
    b1.stall_in    = 1'b0;
  endtask

  initial begin
    int sat;
    idle0();
    idle1();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    push("reset", 1'b0, 32'd0, 16'd0, 16'd0);
    compare_now();
    reset_n = 1'b1;

    // bex via bypass path, taken
    instr0(1'b1, OP_BEX, 1'b0, 1'b0, 1'b1, 32'd5, 32'd0, 32'h40, 17'd0, 27'h0000100, 32'd0);
    push("bex_byp", 1'b1, 32'h100, 16'd1, 16'd1);
    tick();
    idle0();
    push("bex_byp_done", 1'b0, 32'h100, 16'd1, 16'd1);
    tick();

    // bex via RF path, status zero: not taken despite nonzero bypass value
    instr0(1'b1, OP_BEX, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0, 32'h44, 17'd0, 27'h0000200, 32'd0);
    push("bex_rf_nt", 1'b0, 32'h100, 16'd2, 16'd1);
    tick();

    // bne taken with negative offset
    instr0(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h10, 17'h1FFFC, 27'd0, 32'd0);
    push("bne_neg", 1'b1, 32'h0000000C, 16'd3, 16'd2);
    tick();
    idle0();
    push("bne_done", 1'b0, 32'h0000000C, 16'd3, 16'd2);
    tick();

    // blt uses cmp_lt only
    instr0(1'b1, OP_BLT, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h10, 17'h1FFFC, 27'd0, 32'd0);
    push("blt_nt", 1'b0, 32'h0000000C, 16'd4, 16'd2);
    tick();
    instr0(1'b1, OP_BLT, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h20, 17'h00005, 27'd0, 32'd0);
    push("blt_t", 1'b1, 32'h00000025, 16'd5, 16'd3);
    tick();
    idle0();
    push("blt_done", 1'b0, 32'h00000025, 16'd5, 16'd3);
    tick();

    // jr, then stall for 3 cycles during REDIRECT with a different wrong-path jr
    instr0(1'b1, OP_JR, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h30, 17'd0, 27'd0, 32'h0000DEAD);
    push("jr", 1'b1, 32'h0000DEAD, 16'd6, 16'd4);
    tick();
    instr0(1'b1, OP_JR, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h31, 17'd0, 27'd0, 32'h0000BEEF);
    b0.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("jr_stall", 1'b1, 32'h0000DEAD, 16'd6, 16'd4);
      tick();
    end
    idle0();
    push("jr_release", 1'b0, 32'h0000DEAD, 16'd6, 16'd4);
    tick();

    // stall in IDLE blocks the decision, then j, then squashed bne in REDIRECT
    instr0(1'b1, OP_J, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h50, 17'd0, 27'h0000200, 32'd0);
    b0.stall_in = 1'b1;
    push("idle_stall", 1'b0, 32'h0000DEAD, 16'd6, 16'd4);
    tick();
    b0.stall_in = 1'b0;
    push("j", 1'b1, 32'h00000200, 16'd7, 16'd5);
    tick();
    instr0(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h40, 17'd0, 27'd0, 32'd0);
    push("bne_squash", 1'b0, 32'h00000200, 16'd7, 16'd5);
    tick();
    idle0();
    push("after_squash", 1'b0, 32'h00000200, 16'd7, 16'd5);
    tick();

    // jal with widest target field
    instr0(1'b1, OP_JAL, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h60, 17'd0, 27'h7FFFFFF, 32'd0);
    push("jal_max", 1'b1, 32'h07FFFFFF, 16'd8, 16'd6);
    tick();
    idle0();
    push("jal_done", 1'b0, 32'h07FFFFFF, 16'd8, 16'd6);
    tick();

    // non-control-flow opcodes and a bubble are ignored
    instr0(1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 32'h70, 17'd1, 27'h123, 32'd1);
    push("op_00000", 1'b0, 32'h07FFFFFF, 16'd8, 16'd6);
    tick();
    instr0(1'b1, 5'b10101, 1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 32'h70, 17'd1, 27'h123, 32'd1);
    push("op_10101", 1'b0, 32'h07FFFFFF, 16'd8, 16'd6);
    tick();
    instr0(1'b0, OP_BEX, 1'b0, 1'b0, 1'b1, 32'd9, 32'd9, 32'h70, 17'd0, 27'h321, 32'd0);
    push("bubble", 1'b0, 32'h07FFFFFF, 16'd8, 16'd6);
    tick();

    // bex on RF status, then async reset while in REDIRECT
    instr0(1'b1, OP_BEX, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3, 32'h80, 17'd0, 27'h0000300, 32'd0);
    push("bex_rf_t", 1'b1, 32'h00000300, 16'd9, 16'd7);
    tick();
    idle0();
    #2;
    reset_n = 1'b0;
    #1;
    push("async_rst", 1'b0, 32'd0, 16'd0, 16'd0);
    compare_now();
    reset_n = 1'b1;
    push("post_rst", 1'b0, 32'd0, 16'd0, 16'd0);
    tick();

    // saturation on the narrow-counter instance (max 15)
    for (int i = 0; i < 20; i++) begin
      b1.valid_x  = 1'b1;
      b1.opcode_x = OP_J;
      b1.target_x = 27'h55;
      @(posedge clock);
      #1;
      sat = (i + 1 > 15) ? 15 : i + 1;
      chk("sat.redirect", 32'(b1.redirect), 32'd1);
      chk("sat.taken",    32'(b1.taken_cnt), 32'(sat));
      chk("sat.resolved", 32'(b1.resolved_cnt), 32'(sat));
      idle1();
      @(posedge clock);
      #1;
    end
    b1.valid_x  = 1'b1;
    b1.opcode_x = OP_BNE;
    b1.cmp_ne   = 1'b0;
    @(posedge clock);
    #1;
    chk("sat.nt_resolved", 32'(b1.resolved_cnt), 32'd15);
    chk("sat.nt_redirect", 32'(b1.redirect), 32'd0);
    idle1();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
